// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART blocks.
// Used by the transmitter now and intended for a matching receiver later.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  // Clocks per bit when no runtime divisor is supplied (integer division).
  function automatic int unsigned div_default(input int unsigned clk_freq,
                                              input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_sync_fifo.sv
// Small synchronous FIFO with registered storage; head word is visible on data_o.
// A push and a pop in the same cycle are both honoured; a push while full is dropped.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with per-frame divisor, parity and stop-bit selection.
// Frame configuration is captured when a word is popped, so mid-frame changes hit the next frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [DATA_BITS-1:0] data_i,
  output logic                 ready_o,
  input  logic [DIV_W-1:0]     cfg_div_i,
  input  logic [1:0]           cfg_parity_i,
  input  logic                 cfg_stop2_i,
  output logic                 busy_o,
  output logic                 tx_o
);

  localparam int unsigned      CNT_W   = $clog2(DATA_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_DEF = DIV_W'(div_default(CLK_FREQ, BAUD_RATE));

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;

  tx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     timer_q, timer_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]     div_q, div_d;
  parity_e              parity_q, parity_d;
  logic                 stop2_q, stop2_d;
  logic                 par_bit_q, par_bit_d;
  logic                 tx_q, tx_d;
  logic                 tail_q, tail_d;

  logic [DIV_W-1:0]     eff_div;
  parity_e              eff_parity;
  logic                 timer_end;
  logic                 frame_load;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (valid_i),
    .data_i  (data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ready_o = !fifo_full;
  // tail_q stretches busy over the extra cycle that tx_q lags the state register.
  assign busy_o  = !fifo_empty || (state_q != ST_IDLE) || tail_q;
  assign tx_o    = tx_q;

  always_comb begin
    if (cfg_div_i == '0) begin
      eff_div = DIV_DEF;
    end else if (cfg_div_i == DIV_W'(1)) begin
      eff_div = DIV_W'(2);
    end else begin
      eff_div = cfg_div_i;
    end
    case (cfg_parity_i)
      2'b01:   eff_parity = PAR_EVEN;
      2'b10:   eff_parity = PAR_ODD;
      default: eff_parity = PAR_NONE;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    div_d      = div_q;
    parity_d   = parity_q;
    stop2_d    = stop2_q;
    par_bit_d  = par_bit_q;
    fifo_pop   = 1'b0;
    frame_load = 1'b0;
    timer_end  = (timer_q == div_q - DIV_W'(1));
    tail_d     = (state_q != ST_IDLE);

    if (state_q != ST_IDLE) begin
      timer_d = timer_end ? '0 : timer_q + DIV_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) frame_load = 1'b1;
      end
      ST_START: begin
        if (timer_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (timer_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CNT_W'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = (parity_q == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (timer_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        // bit_cnt counts stop bits here; a waiting word starts with no idle gap.
        if (timer_end) begin
          if (stop2_q && (bit_cnt_q == '0)) begin
            bit_cnt_d = CNT_W'(1);
          end else if (!fifo_empty) begin
            frame_load = 1'b1;
          end else begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (frame_load) begin
      fifo_pop  = 1'b1;
      shift_d   = fifo_data;
      div_d     = eff_div;
      parity_d  = eff_parity;
      stop2_d   = cfg_stop2_i;
      par_bit_d = (^fifo_data) ^ (eff_parity == PAR_ODD);
      timer_d   = '0;
      bit_cnt_d = '0;
      state_d   = ST_START;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = par_bit_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      div_q     <= '0;
      parity_q  <= PAR_NONE;
      stop2_q   <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= 1'b1;
      tail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      div_q     <= div_d;
      parity_q  <= parity_d;
      stop2_q   <= stop2_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
      tail_q    <= tail_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: lane 0 is an 8-bit instance, lane 1 a 7-bit one, both at 1 MHz / 100 kBd.
// A per-lane frame model predicts tx/busy/ready every cycle; directed literals pin the model.
module tb_uart_tx_cfg;

  localparam int DEPTH   = 4;
  localparam int DEF_DIV = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid   [2];
  logic [8:0]  data    [2];
  logic [15:0] cfg_div [2];
  logic [1:0]  cfg_par [2];
  logic        stop2   [2];
  logic        ready   [2];
  logic        busy    [2];
  logic        tx      [2];

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;

  logic cap [256];
  logic bsy [256];
  logic rdy [256];

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int NB = (g == 0) ? 8 : 7;

    bit   wave [$];
    int   mfifo [$];
    logic exp_tx, exp_busy, exp_ready;

    uart_tx_cfg #(
      .CLK_FREQ   (1_000_000),
      .BAUD_RATE  (100_000),
      .DATA_BITS  (NB),
      .FIFO_DEPTH (DEPTH),
      .DIV_W      (16)
    ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid[g]),
      .data_i       (data[g][NB-1:0]),
      .ready_o      (ready[g]),
      .cfg_div_i    (cfg_div[g]),
      .cfg_parity_i (cfg_par[g]),
      .cfg_stop2_i  (stop2[g]),
      .busy_o       (busy[g]),
      .tx_o         (tx[g])
    );

    // Model: wave holds the line level for each upcoming clock; a word becomes a frame once the line is free.
    always @(posedge clk) begin : model
      bit had;
      bit acc;
      bit par;
      int w;
      int d;
      if (rst) begin
        wave.delete();
        mfifo.delete();
        exp_tx    = 1'b1;
        exp_busy  = 1'b0;
        exp_ready = 1'b1;
      end else begin
        acc    = valid[g] && (mfifo.size() < DEPTH);
        had    = (wave.size() != 0);
        exp_tx = had ? wave.pop_front() : 1'b1;
        if ((wave.size() == 0) && (mfifo.size() != 0)) begin
          w = mfifo.pop_front();
          d = (cfg_div[g] == 0) ? DEF_DIV : (cfg_div[g] == 1) ? 2 : int'(cfg_div[g]);
          repeat (d) wave.push_back(1'b0);
          par = 1'b0;
          for (int i = 0; i < NB; i++) begin
            repeat (d) wave.push_back(w[i]);
            par ^= w[i];
          end
          if (cfg_par[g] == 2'b01) repeat (d) wave.push_back(par);
          else if (cfg_par[g] == 2'b10) repeat (d) wave.push_back(!par);
          repeat (stop2[g] ? 2 * d : d) wave.push_back(1'b1);
        end
        if (acc) mfifo.push_back(int'(data[g]) & ((1 << NB) - 1));
        exp_ready = (mfifo.size() < DEPTH);
        exp_busy  = had || (wave.size() != 0) || (mfifo.size() != 0);
      end
    end

    always @(negedge clk) begin
      if (check_en) begin
        checkOutput($sformatf("lane%0d_tx", g), tx[g], exp_tx);
        checkOutput($sformatf("lane%0d_busy", g), busy[g], exp_busy);
        checkOutput($sformatf("lane%0d_ready", g), ready[g], exp_ready);
      end
    end
  end

  task automatic setCfg(input int ln, input logic [15:0] div, input logic [1:0] par, input logic s2);
    cfg_div[ln] = div;
    cfg_par[ln] = par;
    stop2[ln]   = s2;
  endtask

  // Pushes nwords words (w0, w0+step, ...) on consecutive edges and records ncyc cycles;
  // index k holds the outputs after the k-th edge following the first accept edge.
  task automatic applyStimulus(input int ln, input logic [8:0] w0, input logic [8:0] step,
                               input int nwords, input int ncyc, input int chg_at,
                               input logic [15:0] chg_div, input int rst_at);
    valid[ln] = 1'b1;
    data[ln]  = w0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cap[i] = tx[ln];
      bsy[i] = busy[ln];
      rdy[i] = ready[ln];
      if (i + 1 < nwords) data[ln] = w0 + step * 9'(i + 1);
      else if (i + 1 == nwords) valid[ln] = 1'b0;
      if (i == chg_at) cfg_div[ln] = chg_div;
      if (i == rst_at) rst = 1'b1;
      else if (i == rst_at + 1) rst = 1'b0;
    end
  endtask

  initial begin
    int lows;
    for (int l = 0; l < 2; l++) begin
      valid[l] = 1'b0;
      data[l]  = '0;
      setCfg(l, 16'd4, 2'b00, 1'b0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_en = 1'b1;
    checkOutput("reset_tx", tx[0], 1);
    checkOutput("reset_busy", busy[0], 0);
    checkOutput("reset_ready", ready[0], 1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] 8N1 div=4 word 0x55");
    applyStimulus(0, 9'h55, 9'h0, 1, 46, -1, 16'd0, -1);
    checkOutput("8n1_idle_after_accept", cap[1], 1);
    checkOutput("8n1_start_first", cap[2], 0);
    checkOutput("8n1_start_last", cap[5], 0);
    checkOutput("8n1_bit0", cap[6], 1);
    checkOutput("8n1_bit1", cap[10], 0);
    checkOutput("8n1_bit7", cap[37], 0);
    checkOutput("8n1_stop", cap[38], 1);
    checkOutput("8n1_busy_last_stop", bsy[41], 1);
    checkOutput("8n1_busy_fall", bsy[42], 0);
    lows = 0;
    for (int k = 0; k < 46; k++) lows += (cap[k] == 1'b0) ? 1 : 0;
    checkOutput("8n1_low_clocks", lows, 20);

    $display("[TB] 7E2 and 7O2 div=4 word 0x03");
    setCfg(1, 16'd4, 2'b01, 1'b1);
    applyStimulus(1, 9'h03, 9'h0, 1, 50, -1, 16'd0, -1);
    checkOutput("7e2_bit6", cap[33], 0);
    checkOutput("7e2_parity", cap[34], 0);
    checkOutput("7e2_stop2_end", cap[45], 1);
    checkOutput("7e2_busy_last", bsy[45], 1);
    checkOutput("7e2_busy_fall", bsy[46], 0);
    setCfg(1, 16'd4, 2'b10, 1'b1);
    applyStimulus(1, 9'h03, 9'h0, 1, 50, -1, 16'd0, -1);
    checkOutput("7o2_parity", cap[34], 1);

    $display("[TB] burst of five words div=4");
    setCfg(0, 16'd4, 2'b00, 1'b0);
    applyStimulus(0, 9'h10, 9'h1, 5, 205, -1, 16'd0, -1);
    checkOutput("burst_ready_k3", rdy[3], 1);
    checkOutput("burst_ready_full", rdy[4], 0);
    checkOutput("burst_ready_still_full", rdy[40], 0);
    checkOutput("burst_ready_after_pop", rdy[41], 1);
    checkOutput("burst_stop_then", cap[41], 1);
    checkOutput("burst_no_gap_start", cap[42], 0);
    checkOutput("burst_busy_last", bsy[201], 1);
    checkOutput("burst_busy_fall", bsy[202], 0);

    $display("[TB] divisor changed to 8 during DATA of first frame");
    applyStimulus(0, 9'h00, 9'h1, 2, 130, 10, 16'd8, -1);
    checkOutput("chg_first_bit7", cap[37], 0);
    checkOutput("chg_first_stop", cap[38], 1);
    checkOutput("chg_second_start", cap[42], 0);
    checkOutput("chg_second_start_end", cap[49], 0);
    checkOutput("chg_second_bit0", cap[50], 1);
    checkOutput("chg_second_bit0_end", cap[57], 1);
    checkOutput("chg_second_bit1", cap[58], 0);
    checkOutput("chg_busy_fall", bsy[122], 0);
    cfg_div[0] = 16'd4;

    $display("[TB] divisor 0 selects default, divisor 1 acts as 2");
    setCfg(0, 16'd0, 2'b00, 1'b0);
    applyStimulus(0, 9'h01, 9'h0, 1, 105, -1, 16'd0, -1);
    checkOutput("div0_start_end", cap[11], 0);
    checkOutput("div0_bit0", cap[12], 1);
    checkOutput("div0_bit0_end", cap[21], 1);
    checkOutput("div0_bit1", cap[22], 0);
    checkOutput("div0_busy_fall", bsy[102], 0);
    setCfg(0, 16'd1, 2'b00, 1'b0);
    applyStimulus(0, 9'h01, 9'h0, 1, 25, -1, 16'd0, -1);
    checkOutput("div1_start_end", cap[3], 0);
    checkOutput("div1_bit0", cap[4], 1);
    checkOutput("div1_bit0_end", cap[5], 1);
    checkOutput("div1_bit1", cap[6], 0);

    $display("[TB] reset during bit 3 of 0xA5, then clean frame");
    setCfg(0, 16'd4, 2'b00, 1'b0);
    applyStimulus(0, 9'hA5, 9'h0, 1, 30, -1, 16'd0, 19);
    checkOutput("rst_bit3_before", cap[19], 0);
    checkOutput("rst_tx_high", cap[20], 1);
    checkOutput("rst_busy_low", bsy[20], 0);
    checkOutput("rst_ready_high", rdy[20], 1);
    applyStimulus(0, 9'h3C, 9'h0, 1, 46, -1, 16'd0, -1);
    checkOutput("post_rst_start", cap[2], 0);
    checkOutput("post_rst_bit1", cap[13], 0);
    checkOutput("post_rst_bit2", cap[14], 1);
    checkOutput("post_rst_busy_last", bsy[41], 1);
    checkOutput("post_rst_busy_fall", bsy[42], 0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Configurable UART transmitter: serialises DATA_BITS-wide words LSB-first with runtime-selectable baud divisor, parity mode and stop-bit count, fronted by a small input FIFO so the user side can burst several words without waiting per frame. It is the parametrised successor to the fixed 8N1 transmitter in the peripherals tree and drops in wherever a console or debug link needs non-8N1 framing or buffered writes.

## Interface
- CLK_FREQ, 50_000_000, system clock frequency in Hz
- BAUD_RATE, 115200, baud rate used when no runtime divisor is supplied
- DATA_BITS, 8, data bits per frame, legal 5..9
- FIFO_DEPTH, 4, input FIFO entries, power of two, at least 2
- DIV_W, 16, width of the runtime divisor input
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- valid_i  in  1  write strobe
- data_i  in  DATA_BITS  word to send, bit 0 transmitted first
- ready_o  out  1  FIFO can accept a word; transfer on valid_i && ready_o
- cfg_div_i  in  DIV_W  clocks per bit; 0 selects CLK_FREQ/BAUD_RATE (integer division), 1 is treated as 2
- cfg_parity_i  in  2  00 none, 01 even, 10 odd, 11 none
- cfg_stop2_i  in  1  0 = one stop bit, 1 = two stop bits
- busy_o  out  1  FIFO non-empty or a frame in flight
- tx_o  out  1  serial line, idle high

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_o=1. If FIFO non-empty: pop head into shift register, latch cfg_div_i/cfg_parity_i/cfg_stop2_i into frame-config registers, go to START.
- START: tx_o=0 for one bit period, then DATA.
- DATA: tx_o=shift[0]; shift right after each bit period; after DATA_BITS bits go to PARITY if parity enabled, else STOP.
- PARITY: even = XOR of the frame's data bits; odd = its inverse. One bit period, then STOP.
- STOP: tx_o=1 for 1 or 2 bit periods. At the end: if FIFO non-empty, pop and latch config, then go directly to START with no idle gap; else go to IDLE.
- Bit timer: counts 0..div-1 from the latched divisor; each bit lasts exactly div clocks. Bit counter is clog2(DATA_BITS+1) wide.
- Config inputs are sampled only at frame start. Changes mid-frame affect the next frame only.
- ready_o = !fifo_full. A push and a pop in the same cycle are both honoured. valid_i while full is ignored, and the word is dropped. Data wider than DATA_BITS does not exist: the port is exactly DATA_BITS wide.
- Reset: state=IDLE, FIFO flushed, tx_o=1, ready_o=1, busy_o=0, all counters 0. Reset mid-frame aborts the frame. tx_o is high on the edge after rst is sampled.

## Timing
- Accepting edge N on an idle, empty block: FIFO non-empty from N+1, pop/latch at N+1, tx_o falls after edge N+2.
- Frame length in clocks = div × (1 + DATA_BITS + P + S), where P ∈ {0,1} and S ∈ {1,2}.
- Back-to-back frames: the next start bit begins on the clock immediately following the last stop-bit clock.
- busy_o deasserts on the clock after the final stop-bit clock when the FIFO is empty.
- tx_o is driven from a flop with no combinational path from inputs.

## Structure
- Package uart_pkg holds: parity_e enum (PAR_NONE, PAR_EVEN, PAR_ODD), tx_state_e enum, and the default-divisor constant function div_default(CLK_FREQ, BAUD_RATE).
- Sub-module sync_fifo (WIDTH, DEPTH): registered storage, push/pop/full/empty, with simultaneous push+pop supported. It is reusable by a later uart_rx_cfg.
- The top level holds the FSM, bit timer, bit counter, shift register and frame-config registers.

## Test plan
- Reset mid-frame: send 0xA5, assert rst during bit 3 → tx_o=1 on the next edge, busy_o=0, ready_o=1, and a new word sends cleanly.
- 8N1, div=4: send 0x55 → tx_o low 4 clks, then 1,0,1,0,1,0,1,0 at 4 clks each, then high 4 clks; frame = 40 clks; falling edge 2 clks after accept.
- Parity/stop: DATA_BITS=7, even parity, 2 stop bits, div=4, send 0x03 → parity bit 0, frame 44 clks; same word with odd parity → parity bit 1.
- Burst/full: FIFO_DEPTH=4, div=4, push 5 words consecutively → ready_o drops after 4 accepts plus the one pop at frame start; all accepted words appear with zero idle gap between stop and start bits; busy_o falls after the last stop bit.
- Mid-frame config change: start a frame at div=4, change to div=8 during DATA → current frame stays at 4 clks/bit, and the queued next frame runs at 8.
- Divisor edge cases: cfg_div_i=0 with CLK_FREQ=1_000_000 and BAUD_RATE=100_000 → 10 clks/bit; cfg_div_i=1 → 2 clks/bit.
